cache_refill: RTL

CACHE_REFILL -- requirements
Module: cache_refill

---
 rtl/cache_pkg.sv | 27 ++
 rtl/cache_refill.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cache_pkg.sv
// Shared types, line geometry and address helper for the cache refill engine.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } refill_state_t;

  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned OFFSET_BITS    = 2;
  localparam int unsigned LINE_BYTES     = 16;
  localparam int unsigned LINE_LSB       = 4;
  localparam int unsigned WORD_LSB       = 2;

  // Byte offset inside the line of word (start + cnt); the sum wraps so it never carries into the line base.
  function automatic logic [LINE_LSB-1:0] line_word_addr(
    input logic [OFFSET_BITS-1:0] start,
    input logic [OFFSET_BITS-1:0] cnt
  );
    logic [OFFSET_BITS-1:0] idx;
    idx = start + cnt;
    return {idx, WORD_LSB'(0)};
  endfunction

endpackage

// File: rtl/cache_refill.sv
// Four-word cache line refill engine: one memory read per word, then a one-cycle fill pulse.
// Build option REFILL_CRITICAL_WORD_FIRST_EN: fetch from the missed word first and pulse crit_valid early.
module cache_refill
  import cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_req,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic [DATA_WIDTH-1:0] d0,
  output logic [DATA_WIDTH-1:0] d1,
  output logic [DATA_WIDTH-1:0] d2,
  output logic [DATA_WIDTH-1:0] d3,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic                  fill_valid,
  output logic                  crit_valid,
  output logic                  busy
);

  refill_state_t          state_q, state_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic [OFFSET_BITS-1:0] start_q, start_d;
  logic [OFFSET_BITS-1:0] word_idx;
  logic [ADDR_WIDTH-1:0]  fill_addr_q, fill_addr_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  line_q [WORDS_PER_LINE];
  logic [DATA_WIDTH-1:0]  line_d [WORDS_PER_LINE];
  logic                   mem_rd_en_q, mem_rd_en_d;
  logic                   fill_valid_q, fill_valid_d;
  logic                   crit_valid_q, crit_valid_d;
  logic                   busy_q, busy_d;

  // Next state plus next values of every registered output.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_d      = start_q;
    fill_addr_d  = fill_addr_q;
    line_d       = line_q;
    crit_valid_d = 1'b0;
    word_idx     = start_q + cnt_q;

    unique case (state_q)
      IDLE: begin
        if (miss_req) begin
          fill_addr_d = {miss_addr[ADDR_WIDTH-1:LINE_LSB], LINE_LSB'(0)};
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
          start_d     = miss_addr[LINE_LSB-1:WORD_LSB];
`else
          start_d     = '0;
`endif
          cnt_d       = '0;
          state_d     = REQ;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (mem_rvalid) begin
          line_d[word_idx] = mem_rdata;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
          crit_valid_d = (cnt_q == '0);
`endif
          if (cnt_q == OFFSET_BITS'(WORDS_PER_LINE - 1)) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + OFFSET_BITS'(1);
            state_d = REQ;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state so they line up with the state they describe.
    mem_rd_en_d  = (state_d == REQ);
    mem_addr_d   = (state_d == REQ)
                 ? {fill_addr_d[ADDR_WIDTH-1:LINE_LSB], line_word_addr(start_d, cnt_d)}
                 : mem_addr_q;
    fill_valid_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
`ifndef REFILL_CRITICAL_WORD_FIRST_EN
    crit_valid_d = (state_d == DONE);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      start_q      <= '0;
      fill_addr_q  <= '0;
      mem_addr_q   <= '0;
      mem_rd_en_q  <= 1'b0;
      fill_valid_q <= 1'b0;
      crit_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < WORDS_PER_LINE; i++) line_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      fill_addr_q  <= fill_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_en_q  <= mem_rd_en_d;
      fill_valid_q <= fill_valid_d;
      crit_valid_q <= crit_valid_d;
      busy_q       <= busy_d;
      line_q       <= line_d;
    end
  end

  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign fill_addr  = fill_addr_q;
  assign fill_valid = fill_valid_q;
  assign crit_valid = crit_valid_q;
  assign busy       = busy_q;
  assign d0         = line_q[0];
  assign d1         = line_q[1];
  assign d2         = line_q[2];
  assign d3         = line_q[3];

endmodule
